// File: rtl/iob_wb_sim_mem.sv
// -----------------------------------------------------------------------------
// iob_wb_sim_mem
//
// Wishbone B3 slave memory model for the ethmac simulation wrapper. It serves
// the MAC DMA master port and supports two kinds of access:
//   - classic single cycles
//   - registered-feedback bursts (constant and incrementing, with linear or
//     wrap-4/8/16 addressing)
// A fixed number of wait states is inserted before the first ack of every
// cycle or burst. Later beats of a burst run at one word per clock.
//
// Ports:
//   wb_clk_i  - clock
//   wb_rst_i  - synchronous active-high reset (FSM only, memory not cleared)
//   wb_adr_i  - byte address, bits [1:0] ignored
//   wb_dat_i  - write data
//   wb_dat_o  - read data, nonzero only while wb_ack_o is high
//   wb_sel_i  - byte enables for writes
//   wb_we_i   - write enable
//   wb_cyc_i  - cycle valid; dropping it aborts the access
//   wb_stb_i  - strobe
//   wb_cti_i  - cycle type (000 classic, 001 const, 010 incr, 111 end)
//   wb_bte_i  - burst type (00 linear, 01 wrap4, 10 wrap8, 11 wrap16)
//   wb_ack_o  - acknowledge
//   wb_err_o  - error
//
// Optional feature (macro WB_SIM_MEM_ERR_EN):
//   - Defined: a beat whose address has any bit set above MEM_ADDR_W is
//     answered with wb_err_o instead of wb_ack_o. That beat does no write and
//     ends the burst.
//   - Undefined: wb_err_o stays 0 and such addresses alias into the memory.
//
// Memory contents start undefined. The HEXFILE image is loaded by the
// enclosing simulation into the 'mem' array.
// -----------------------------------------------------------------------------
module iob_wb_sim_mem #(
  parameter int    ADDR_W      = 32,
  parameter int    DATA_W      = 32,
  parameter int    MEM_ADDR_W  = 16,
  parameter int    WAIT_STATES = 1,
  parameter string HEXFILE     = "none"
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic [2:0]        wb_cti_i,
  input  logic [1:0]        wb_bte_i,
  output logic              wb_ack_o,
  output logic              wb_err_o
);

  localparam int          WORD_W   = ADDR_W - 2;
  localparam int          IDX_W    = MEM_ADDR_W - 2;
  localparam int          DEPTH    = 1 << IDX_W;
  localparam logic [3:0]  WAIT_CNT = 4'(WAIT_STATES);
  localparam string       unusedHexFile = HEXFILE;

  typedef enum logic [1:0] {IDLE, WAIT, BEAT} stateT;

  stateT             state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] addrInc, addrNext;
  logic [DATA_W-1:0] rdData_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic beatTaken;
  logic outOfRange;
  logic burstContinues;
  logic unusedAdrLsb;

  assign unusedAdrLsb = ^wb_adr_i[1:0];

  // A beat is taken in any BEAT cycle with stb high. The ack is gated by stb
  // rather than cyc, so an ack that is already showing still completes when
  // the master drops cyc in that same cycle.
  assign beatTaken      = (state_q == BEAT) && wb_stb_i;
  assign burstContinues = (wb_cti_i == 3'b001) || (wb_cti_i == 3'b010);

`ifdef WB_SIM_MEM_ERR_EN
  assign outOfRange = |addr_q[WORD_W-1:IDX_W];
`else
  assign outOfRange = 1'b0;
`endif

  // The incrementing-burst address only moves inside the aligned 4/8/16-word
  // block chosen by bte. The bits above the block are kept from the current
  // address.
  assign addrInc = addr_q + WORD_W'(1);

  always_comb begin
    addrNext = addrInc;
    case (wb_bte_i)
      2'b01:   addrNext = {addr_q[WORD_W-1:2], addrInc[1:0]};
      2'b10:   addrNext = {addr_q[WORD_W-1:3], addrInc[2:0]};
      2'b11:   addrNext = {addr_q[WORD_W-1:4], addrInc[3:0]};
      default: addrNext = addrInc;
    endcase
  end

  // State register. Read data is prefetched from the address the next cycle
  // will use, so the data for a burst beat is already in a register when its
  // ack goes high and reads run without bubbles.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      rdData_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      rdData_q <= mem[addr_d[IDX_W-1:0]];
    end
  end

  // Next-state logic:
  //   - IDLE: latch the word address and start the wait-state count.
  //   - WAIT: count down; the ack cycle (BEAT) follows the cycle where the
  //     count is 1.
  //   - BEAT: a classic or end-of-burst beat, an error, or a dropped cyc
  //     returns to IDLE.
  //   - A BEAT cycle with stb low holds the address and stays in BEAT, so the
  //     burst resumes with no new wait states.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          addr_d  = wb_adr_i[ADDR_W-1:2];
          cnt_d   = WAIT_CNT;
          state_d = (WAIT_STATES > 0) ? WAIT : BEAT;
        end
      end
      WAIT: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_d = BEAT;
        end
      end
      BEAT: begin
        if (!wb_cyc_i || (beatTaken && (outOfRange || !burstContinues))) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (beatTaken && (wb_cti_i == 3'b010)) begin
          addr_d = addrNext;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: ack or err only in a BEAT cycle with stb high. Read data is
  // driven only while ack is high and is forced to zero at all other times.
  always_comb begin
    wb_ack_o = 1'b0;
    wb_err_o = 1'b0;
    wb_dat_o = '0;
    if (beatTaken) begin
      if (outOfRange) begin
        wb_err_o = 1'b1;
      end else begin
        wb_ack_o = 1'b1;
        wb_dat_o = rdData_q;
      end
    end
  end

  // Byte-lane write. It happens only on an acked beat and never on a cycle
  // where reset is asserted.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i && beatTaken && !outOfRange && wb_we_i) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (wb_sel_i[b]) mem[addr_q[IDX_W-1:0]][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_iob_wb_sim_mem.sv
// -----------------------------------------------------------------------------
// tb_iob_wb_sim_mem
//
// Scoreboard bench for iob_wb_sim_mem with one wait state and a 64 KiB
// memory. For every beat it presents, the driver pushes the expected response
// into a queue: the cycle the ack or err must appear in, its kind, and the
// read data. A separate monitor pops an entry on every ack or err and compares
// it. Any response that arrives when nothing is queued is reported.
// -----------------------------------------------------------------------------
module tb_iob_wb_sim_mem;

  localparam int WS = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] wbAdr;
  logic [31:0] wbDatW;
  logic [31:0] wbDatR;
  logic [3:0]  wbSel;
  logic        wbWe;
  logic        wbCyc;
  logic        wbStb;
  logic [2:0]  wbCti;
  logic [1:0]  wbBte;
  logic        wbAck;
  logic        wbErr;

  typedef struct {
    int          cycle;
    bit          isRead;
    bit          isErr;
    logic [31:0] data;
  } expT;

  expT         expQ[$];
  int          cycleCount = 0;
  int          checks = 0;
  int          passes = 0;
  logic [31:0] beatAdr [16];
  logic [31:0] beatDat [16];
  logic [31:0] beatExp [16];
  bit          beatErr [16];

  iob_wb_sim_mem #(
    .ADDR_W(32),
    .DATA_W(32),
    .MEM_ADDR_W(16),
    .WAIT_STATES(WS),
    .HEXFILE("none")
  ) dut (
    .wb_clk_i(clock),
    .wb_rst_i(reset),
    .wb_adr_i(wbAdr),
    .wb_dat_i(wbDatW),
    .wb_dat_o(wbDatR),
    .wb_sel_i(wbSel),
    .wb_we_i(wbWe),
    .wb_cyc_i(wbCyc),
    .wb_stb_i(wbStb),
    .wb_cti_i(wbCti),
    .wb_bte_i(wbBte),
    .wb_ack_o(wbAck),
    .wb_err_o(wbErr)
  );

  // Free-running clock. The cycle counter is read after each rising edge to
  // time-stamp every beat.
  always #5 clock = ~clock;

  always @(posedge clock) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                  name, actual, expected, cycleCount);
  endtask

  task automatic busIdle();
    wbCyc  = 1'b0;
    wbStb  = 1'b0;
    wbWe   = 1'b0;
    wbAdr  = '0;
    wbDatW = '0;
    wbSel  = '0;
    wbCti  = 3'b000;
    wbBte  = 2'b00;
  endtask

  task automatic setBeat(input int i, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [31:0] exp);
    beatAdr[i] = adr;
    beatDat[i] = dat;
    beatExp[i] = exp;
    beatErr[i] = 1'b0;
  endtask

  // Waits a bounded number of cycles for the slave to answer the beat on the
  // bus. A timeout counts as a failed check so the run still finishes.
  task automatic waitBeat(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (wbAck || wbErr) begin
        got = 1'b1;
        return;
      end
    end
    checks++;
    $display("[TB] FAIL beatTimeout: no ack/err within 20 cycles at cycle %0d, required one",
             cycleCount);
  endtask

  // Drives one classic cycle or one burst built from the beat tables. A
  // burst ends with cti=111 on its last beat. Optionally, stb is dropped for
  // gapLen cycles before beat gapAfter. The first beat must be answered
  // 1+WS cycles after its stb goes high. Each later beat must be answered in
  // the same cycle its stb is presented.
  task automatic applyStimulus(input bit isWrite, input logic [2:0] ctiMode,
                               input logic [1:0] bteMode, input int nBeats,
                               input int gapAfter, input int gapLen,
                               input logic [3:0] selMask);
    bit  got;
    expT e;
    @(posedge clock); #1;
    wbCyc = 1'b1;
    wbWe  = isWrite;
    wbSel = selMask;
    wbBte = bteMode;
    for (int i = 0; i < nBeats; i++) begin
      if (i == gapAfter && gapLen > 0) begin
        wbStb = 1'b0;
        repeat (gapLen) @(posedge clock);
        #1;
      end
      wbStb  = 1'b1;
      wbAdr  = beatAdr[i];
      wbDatW = beatDat[i];
      if (ctiMode == 3'b000)     wbCti = 3'b000;
      else if (i == nBeats - 1)  wbCti = 3'b111;
      else                       wbCti = ctiMode;
      e.cycle  = (i == 0) ? cycleCount + 1 + WS : cycleCount;
      e.isRead = !isWrite;
      e.isErr  = beatErr[i];
      e.data   = beatExp[i];
      expQ.push_back(e);
      waitBeat(got);
      @(posedge clock); #1;
      if (!got) begin
        void'(expQ.pop_back());
        break;
      end
    end
    busIdle();
  endtask

  task automatic classicWrite(input logic [31:0] adr, input logic [31:0] dat,
                              input logic [3:0] sel);
    setBeat(0, adr, dat, 32'h0);
    applyStimulus(1'b1, 3'b000, 2'b00, 1, -1, 0, sel);
  endtask

  task automatic classicRead(input logic [31:0] adr, input logic [31:0] exp);
    setBeat(0, adr, 32'h0, exp);
    applyStimulus(1'b0, 3'b000, 2'b00, 1, -1, 0, 4'hF);
  endtask

  // Monitor: every ack or err pops one expected entry and checks its timing,
  // its kind, and its data. The data is checked for reads and for err beats,
  // which must return zero. While a cycle is open and there is no response,
  // the read data must be zero.
  initial begin : monitor
    expT e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (wbAck || wbErr) begin
          if (expQ.size() == 0) begin
            checks++;
            $display("[TB] FAIL unexpectedBeat: ack=%0b err=%0b at cycle %0d, required no response",
                     wbAck, wbErr, cycleCount);
          end else begin
            e = expQ.pop_front();
            checkOutput("beatCycle", 32'(cycleCount), 32'(e.cycle));
            checkOutput("beatAck", 32'(wbAck), 32'(!e.isErr));
            checkOutput("beatErr", 32'(wbErr), 32'(e.isErr));
            if (e.isRead || e.isErr) checkOutput("readData", wbDatR, e.data);
          end
        end else if (wbCyc) begin
          checkOutput("idleData", wbDatR, 32'h0);
        end
      end
    end
  end

  // Hard time limit in case the bench itself gets stuck.
  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence; each step's expected values are written out by hand.
  initial begin : stimulus
    busIdle();
    for (int i = 0; i < 16; i++) setBeat(i, 32'h0, 32'h0, 32'h0);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("resetAck", 32'(wbAck), 32'h0);
    checkOutput("resetErr", 32'(wbErr), 32'h0);
    checkOutput("resetDat", wbDatR, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Full-word write and read-back, then a single-byte-lane merge.
    classicWrite(32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
    classicRead (32'h0000_0100, 32'hDEAD_BEEF);
    classicWrite(32'h0000_0100, 32'h0000_AB00, 4'b0010);
    classicRead (32'h0000_0100, 32'hDEAD_ABEF);

    // Wrap-4 incrementing read burst from 0x208 walks 208, 20C, 200, 204.
    classicWrite(32'h0000_0200, 32'hA0A0_A0A0, 4'hF);
    classicWrite(32'h0000_0204, 32'hA1A1_A1A1, 4'hF);
    classicWrite(32'h0000_0208, 32'hA2A2_A2A2, 4'hF);
    classicWrite(32'h0000_020C, 32'hA3A3_A3A3, 4'hF);
    setBeat(0, 32'h0000_0208, 32'h0, 32'hA2A2_A2A2);
    setBeat(1, 32'h0000_020C, 32'h0, 32'hA3A3_A3A3);
    setBeat(2, 32'h0000_0200, 32'h0, 32'hA0A0_A0A0);
    setBeat(3, 32'h0000_0204, 32'h0, 32'hA1A1_A1A1);
    applyStimulus(1'b0, 3'b010, 2'b01, 4, -1, 0, 4'hF);
    // The slave must be back in IDLE: normal latency again.
    classicRead(32'h0000_0200, 32'hA0A0_A0A0);

    // Linear 8-beat write burst with stb low for two cycles before beat 4.
    for (int i = 0; i < 8; i++)
      setBeat(i, 32'h0000_0400 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 32'h0);
    applyStimulus(1'b1, 3'b010, 2'b00, 8, 3, 2, 4'hF);
    // Linear read-back of all eight words as one burst.
    for (int i = 0; i < 8; i++)
      setBeat(i, 32'h0000_0400 + 32'(4 * i), 32'h0, 32'hC0DE_0000 + 32'(i));
    applyStimulus(1'b0, 3'b010, 2'b00, 8, -1, 0, 4'hF);

    // Wrap-8 read from 0x418 walks 418, 41C, 400, 404.
    setBeat(0, 32'h0000_0418, 32'h0, 32'hC0DE_0006);
    setBeat(1, 32'h0000_041C, 32'h0, 32'hC0DE_0007);
    setBeat(2, 32'h0000_0400, 32'h0, 32'hC0DE_0000);
    setBeat(3, 32'h0000_0404, 32'h0, 32'hC0DE_0001);
    applyStimulus(1'b0, 3'b010, 2'b10, 4, -1, 0, 4'hF);

    // Constant-address burst rereads the same word.
    for (int i = 0; i < 3; i++) setBeat(i, 32'h0000_0404, 32'h0, 32'hC0DE_0001);
    applyStimulus(1'b0, 3'b001, 2'b00, 3, -1, 0, 4'hF);

    // Write aborted by dropping cyc during the wait state: no ack, no write.
    @(posedge clock); #1;
    wbCyc = 1'b1; wbStb = 1'b1; wbWe = 1'b1; wbSel = 4'hF; wbCti = 3'b000;
    wbAdr = 32'h0000_0100; wbDatW = 32'h1234_5678;
    @(posedge clock); #1;
    busIdle();
    repeat (3) @(posedge clock);
    classicRead(32'h0000_0100, 32'hDEAD_ABEF);

    // Reset during the wait state of a write: no ack, memory untouched.
    @(posedge clock); #1;
    wbCyc = 1'b1; wbStb = 1'b1; wbWe = 1'b1; wbSel = 4'hF; wbCti = 3'b000;
    wbAdr = 32'h0000_0200; wbDatW = 32'h8765_4321;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    busIdle();
    @(negedge clock);
    checkOutput("postResetAck", 32'(wbAck), 32'h0);
    repeat (2) @(posedge clock);
    classicRead(32'h0000_0200, 32'hA0A0_A0A0);

    // Address above the implemented range: error beat or alias of word 0.
    classicWrite(32'h0000_0000, 32'hA5A5_0000, 4'hF);
`ifdef WB_SIM_MEM_ERR_EN
    setBeat(0, 32'h0001_0000, 32'h0, 32'h0);
    beatErr[0] = 1'b1;
`else
    setBeat(0, 32'h0001_0000, 32'h0, 32'hA5A5_0000);
`endif
    applyStimulus(1'b0, 3'b000, 2'b00, 1, -1, 0, 4'hF);

    repeat (4) @(posedge clock);
    checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
